letter_ps2_encoder: RTL and testbench
=====================================

Name: letter_ps2_encoder

Overview:
Converts a 5-bit letter code into a PS/2 keyboard keystroke and transmits it device-side. The letter code uses the team's encoding: a=0 … z=25, ENTR=31. Each accepted code is mapped to its Set-2 scan code and serialized as 11-bit PS/2 frames: a make code, then optionally the break sequence F0 followed by the make code. The block is used for keyboard emulation and as a loopback driver into the PS/2 receive/keycode-decode path.

Parameters:
CLK_DIV, 4000, clk cycles per PS/2 clock half-period (12.5 kHz at 100 MHz); legal range ≥2.
GAP_CYCLES, 8000, idle cycles with both lines high after every frame; legal range ≥1.
SEND_BREAK, 1, 1 sends make+F0+make; 0 sends the make byte only.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
letter_in  in  5  letter code (0–25 = a–z, 31 = ENTR)
letter_valid  in  1  letter_in is valid this cycle
letter_ready  out  1  block can accept a code
ps2_clk_out  out  1  generated PS/2 clock; idles high
ps2_data_out  out  1  PS/2 data; idles high
busy  out  1  keystroke transmission in progress
code_err  out  1  one-cycle pulse when an unmapped code is accepted

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: ps2_clk_out=1, ps2_data_out=1, letter_ready=1, busy=0, code_err=0. State is IDLE, counters are 0.
- A reset asserted mid-frame aborts immediately. Lines return high and no partial byte is resumed.
- Handshake: letter_ready=1 only in IDLE. A code is accepted on a rising edge where letter_valid && letter_ready. letter_in is captured on that edge and later changes are ignored. letter_valid while not ready has no effect and is not queued.
- Scan code map (hex): a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A ENTR5A.
- Unmapped codes (26–30):
  - On the accept edge, code_err=1 for exactly one cycle.
  - No PS/2 activity occurs and busy stays 0.
  - letter_ready drops for that one cycle, then returns to 1.
- Valid code, accept edge: letter_ready←0 and busy←1. The start bit is driven from the next cycle (latency 1).
- Frame format: start(0), 8 data bits LSB first, odd parity (total count of ones in data+parity is odd), stop(1).
- Bit timing:
  - Each bit has a high phase then a low phase, each CLK_DIV cycles long.
  - ps2_data_out changes only at the start of a high phase and is stable while ps2_clk_out is low.
  - One frame takes 22*CLK_DIV cycles, giving exactly 11 falling edges of ps2_clk_out.
- Between frames: GAP_CYCLES cycles with both lines high.
- Byte sequence: SEND_BREAK=1 gives make, F0, make (3 frames). SEND_BREAK=0 gives make only.
- After the last gap: state IDLE, busy←0, letter_ready←1 on the same edge.
- Total keystroke duration (SEND_BREAK=1): 3*(22*CLK_DIV + GAP_CYCLES) cycles from the first start-bit cycle to ready.
- FSM states and transitions:
  - IDLE → START on a valid mapped accept. IDLE → ERR on an unmapped accept.
  - ERR → IDLE after 1 cycle.
  - START → DATA → PARITY → STOP.
  - STOP → GAP.
  - GAP → START (next byte pending) or GAP → IDLE.
- Counters:
  - Half-period counter: width ceil(log2(CLK_DIV)). Wraps at CLK_DIV-1 and toggles the phase.
  - Bit index: 0–7.
  - Byte index: 0–2.
  - Gap counter: sized for GAP_CYCLES.
- No receive/host-inhibit support. The ps2 lines are push-pull outputs; open-drain conversion is done at top level.

Decomposition:
- Shared package letter_pkg:
  - 5-bit letter constants a…z and ENTR (=5'b11111), shared with the keycode decoder.
  - 8-bit scan code constants and BREAK_PREFIX=8'hF0.
  - A letter-to-scancode function that returns a valid flag.
- Sub-module ps2_byte_tx:
  - Serializes one byte with parity and timing.
  - Handshake: byte_in/start/done.
  - Parameter: CLK_DIV.
- letter_ps2_encoder holds the sequencing FSM (IDLE/ERR/byte sequencing/GAP), the lookup and the handshake.

Test Plan:
1. CLK_DIV=4, GAP_CYCLES=8, SEND_BREAK=1; send code 0 ('a') → three frames. 1C frame sampled on falling edges: 0,0,0,1,1,1,0,0,0,0,1. F0 frame: 0,0,0,0,0,1,1,1,1,1,1. Then 1C again. busy high for 3*(88+8) cycles.
2. Send 31 (ENTR) → data 5A, parity 1, frame 0,0,1,0,1,1,0,1,0,1,1. Send 12 ('m') → 3A, parity 1.
3. Send 27 → code_err high exactly 1 cycle, zero ps2_clk_out edges, letter_ready back to 1 the next cycle.
4. Hold letter_valid high with changing letter_in during a transmission → no extra accept. The next code is accepted only on the edge where letter_ready=1.
5. Assert rst_n low mid data bit 4 of the F0 frame → ps2_clk_out=ps2_data_out=1 and letter_ready=1 asynchronously. After release, a new 'q' (16) yields 15/F0/15 cleanly.
6. SEND_BREAK=0; send 'z' (25) → a single 1A frame, then ready after 88+8 cycles. Check data is stable during every low phase of ps2_clk_out.

Source files
------------

// File: rtl/letter_pkg.sv
// Letter/scan-code definitions shared by the PS/2 encoder and the keycode decoder.
//   - 5-bit letter codes: a=0 .. z=25, ENTR=31 (26..30 are unmapped)
//   - PS/2 Set-2 make codes for each letter and the break prefix F0
//   - letter_to_scan(): letter code -> {valid, make code}
package letter_pkg;

    localparam logic [4:0] LTR_A    = 5'd0;
    localparam logic [4:0] LTR_B    = 5'd1;
    localparam logic [4:0] LTR_C    = 5'd2;
    localparam logic [4:0] LTR_D    = 5'd3;
    localparam logic [4:0] LTR_E    = 5'd4;
    localparam logic [4:0] LTR_F    = 5'd5;
    localparam logic [4:0] LTR_G    = 5'd6;
    localparam logic [4:0] LTR_H    = 5'd7;
    localparam logic [4:0] LTR_I    = 5'd8;
    localparam logic [4:0] LTR_J    = 5'd9;
    localparam logic [4:0] LTR_K    = 5'd10;
    localparam logic [4:0] LTR_L    = 5'd11;
    localparam logic [4:0] LTR_M    = 5'd12;
    localparam logic [4:0] LTR_N    = 5'd13;
    localparam logic [4:0] LTR_O    = 5'd14;
    localparam logic [4:0] LTR_P    = 5'd15;
    localparam logic [4:0] LTR_Q    = 5'd16;
    localparam logic [4:0] LTR_R    = 5'd17;
    localparam logic [4:0] LTR_S    = 5'd18;
    localparam logic [4:0] LTR_T    = 5'd19;
    localparam logic [4:0] LTR_U    = 5'd20;
    localparam logic [4:0] LTR_V    = 5'd21;
    localparam logic [4:0] LTR_W    = 5'd22;
    localparam logic [4:0] LTR_X    = 5'd23;
    localparam logic [4:0] LTR_Y    = 5'd24;
    localparam logic [4:0] LTR_Z    = 5'd25;
    localparam logic [4:0] LTR_ENTR = 5'b11111;

    localparam logic [7:0] SC_A    = 8'h1C;
    localparam logic [7:0] SC_B    = 8'h32;
    localparam logic [7:0] SC_C    = 8'h21;
    localparam logic [7:0] SC_D    = 8'h23;
    localparam logic [7:0] SC_E    = 8'h24;
    localparam logic [7:0] SC_F    = 8'h2B;
    localparam logic [7:0] SC_G    = 8'h34;
    localparam logic [7:0] SC_H    = 8'h33;
    localparam logic [7:0] SC_I    = 8'h43;
    localparam logic [7:0] SC_J    = 8'h3B;
    localparam logic [7:0] SC_K    = 8'h42;
    localparam logic [7:0] SC_L    = 8'h4B;
    localparam logic [7:0] SC_M    = 8'h3A;
    localparam logic [7:0] SC_N    = 8'h31;
    localparam logic [7:0] SC_O    = 8'h44;
    localparam logic [7:0] SC_P    = 8'h4D;
    localparam logic [7:0] SC_Q    = 8'h15;
    localparam logic [7:0] SC_R    = 8'h2D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_T    = 8'h2C;
    localparam logic [7:0] SC_U    = 8'h3C;
    localparam logic [7:0] SC_V    = 8'h2A;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_X    = 8'h22;
    localparam logic [7:0] SC_Y    = 8'h35;
    localparam logic [7:0] SC_Z    = 8'h1A;
    localparam logic [7:0] SC_ENTR = 8'h5A;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } scan_lookup_t;

    function automatic scan_lookup_t letter_to_scan(input logic [4:0] letter);
        scan_lookup_t r;
        r.valid = 1'b1;
        r.code  = 8'h00;
        case (letter)
            LTR_A:    r.code = SC_A;
            LTR_B:    r.code = SC_B;
            LTR_C:    r.code = SC_C;
            LTR_D:    r.code = SC_D;
            LTR_E:    r.code = SC_E;
            LTR_F:    r.code = SC_F;
            LTR_G:    r.code = SC_G;
            LTR_H:    r.code = SC_H;
            LTR_I:    r.code = SC_I;
            LTR_J:    r.code = SC_J;
            LTR_K:    r.code = SC_K;
            LTR_L:    r.code = SC_L;
            LTR_M:    r.code = SC_M;
            LTR_N:    r.code = SC_N;
            LTR_O:    r.code = SC_O;
            LTR_P:    r.code = SC_P;
            LTR_Q:    r.code = SC_Q;
            LTR_R:    r.code = SC_R;
            LTR_S:    r.code = SC_S;
            LTR_T:    r.code = SC_T;
            LTR_U:    r.code = SC_U;
            LTR_V:    r.code = SC_V;
            LTR_W:    r.code = SC_W;
            LTR_X:    r.code = SC_X;
            LTR_Y:    r.code = SC_Y;
            LTR_Z:    r.code = SC_Z;
            LTR_ENTR: r.code = SC_ENTR;
            default:  r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_byte_tx.sv
// Device-side PS/2 byte serializer.
// Sends one 11-bit frame (start 0, 8 data bits LSB first, odd parity, stop 1).
// Each bit is a high phase followed by a low phase of CLK_DIV cycles each;
// data only changes at the start of a high phase.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - begin a frame with byte_i (ignored while a frame is running);
//                 the start bit appears on the edge that samples start_i
//   byte_i      - byte to send, sampled together with start_i
//   ps2_clk_o   - generated PS/2 clock, idles high
//   ps2_data_o  - PS/2 data, idles high
//   bit_idx_o   - frame bit currently on the line (0 = start .. 10 = stop)
//   done_o      - high in the second-to-last cycle of the stop bit, so a
//                 registered consumer sees the frame end on the edge the
//                 frame actually finishes
module ps2_byte_tx #(
    parameter int CLK_DIV = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic [3:0] bit_idx_o,
    output logic       done_o
);

    localparam int HW = $clog2(CLK_DIV);

    logic          active_q, active_d;
    logic          low_q, low_d;
    logic          clk_q, clk_d;
    logic          data_q, data_d;
    logic [HW-1:0] half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   frame_q, frame_d;
    logic          half_wrap;

    assign half_wrap  = (half_q == HW'(CLK_DIV - 1));
    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = data_q;
    assign bit_idx_o  = bit_q;
    assign done_o     = active_q && low_q && (bit_q == 4'd10) &&
                        (half_q == HW'(CLK_DIV - 2));

    always_comb begin
        active_d = active_q;
        low_d    = low_q;
        clk_d    = clk_q;
        data_d   = data_q;
        half_d   = half_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        if (!active_q) begin
            if (start_i) begin
                active_d = 1'b1;
                low_d    = 1'b0;
                half_d   = '0;
                bit_d    = 4'd0;
                // ~^ gives odd parity over data+parity
                frame_d  = {1'b1, ~^byte_i, byte_i, 1'b0};
                clk_d    = 1'b1;
                data_d   = 1'b0;
            end
        end else if (half_wrap) begin
            half_d = '0;
            low_d  = ~low_q;
            if (!low_q) begin
                clk_d = 1'b0;
            end else begin
                // End of a low phase: rising clock, next bit goes on the line
                clk_d = 1'b1;
                if (bit_q == 4'd10) begin
                    active_d = 1'b0;
                    bit_d    = 4'd0;
                    data_d   = 1'b1;
                end else begin
                    bit_d  = bit_q + 4'd1;
                    data_d = frame_q[bit_q + 4'd1];
                end
            end
        end else begin
            half_d = half_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            low_q    <= 1'b0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
            half_q   <= '0;
            bit_q    <= 4'd0;
            frame_q  <= '0;
        end else begin
            active_q <= active_d;
            low_q    <= low_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
        end
    end

endmodule

// File: rtl/letter_ps2_encoder.sv
// Letter code to PS/2 keystroke encoder (device side).
// Accepts a 5-bit letter code, looks up its Set-2 make code and sends
// make [+ F0 + make] as PS/2 frames, each followed by GAP_CYCLES idle cycles.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   letter_in     - letter code (0..25 = a..z, 31 = ENTR)
//   letter_valid  - letter_in valid this cycle
//   letter_ready  - high only in IDLE; accept = letter_valid && letter_ready
//   ps2_clk_out   - PS/2 clock (push-pull), idles high
//   ps2_data_out  - PS/2 data (push-pull), idles high
//   busy          - keystroke in progress
//   code_err      - one-cycle pulse when an unmapped code is accepted
module letter_ps2_encoder
    import letter_pkg::*;
#(
    parameter int CLK_DIV    = 4000,
    parameter int GAP_CYCLES = 8000,
    parameter int SEND_BREAK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] letter_in,
    input  logic       letter_valid,
    output logic       letter_ready,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       busy,
    output logic       code_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ERR    = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
    localparam logic [2:0] ST_GAP    = 3'd6;

    localparam int         GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [1:0] LAST_BYTE = (SEND_BREAK != 0) ? 2'd2 : 2'd0;

    logic [2:0]    state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          go_q, go_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    scan_lookup_t  lookup;
    logic [7:0]    tx_byte;
    logic [3:0]    tx_bit;
    logic          tx_done;

    assign lookup  = letter_to_scan(letter_in);
    // Byte 1 of a make/break sequence is always the F0 prefix
    assign tx_byte = (byte_idx_q == 2'd1) ? BREAK_PREFIX : code_q;

    assign letter_ready = ready_q;
    assign busy         = busy_q;
    assign code_err     = err_q;

    ps2_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (go_q),
        .byte_i     (tx_byte),
        .ps2_clk_o  (ps2_clk_out),
        .ps2_data_o (ps2_data_out),
        .bit_idx_o  (tx_bit),
        .done_o     (tx_done)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        byte_idx_d = byte_idx_q;
        gap_d      = gap_q;
        go_d       = 1'b0;
        ready_d    = ready_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (letter_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (lookup.valid) begin
                        state_d    = ST_START;
                        code_d     = lookup.code;
                        byte_idx_d = 2'd0;
                        go_d       = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_START:  if (tx_bit == 4'd1)  state_d = ST_DATA;
            ST_DATA:   if (tx_bit == 4'd9)  state_d = ST_PARITY;
            ST_PARITY: if (tx_bit == 4'd10) state_d = ST_STOP;
            ST_STOP: begin
                // tx_done leads the frame end by one cycle, so the gap
                // count starts one cycle early; the thresholds below
                // account for that
                if (tx_done) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (byte_idx_q != LAST_BYTE) begin
                    // go_q is registered, so it is raised one cycle before
                    // the next start bit must appear
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_d    = ST_START;
                        go_d       = 1'b1;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else if (gap_q == GW'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= 8'h00;
            byte_idx_q <= 2'd0;
            gap_q      <= '0;
            go_q       <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            byte_idx_q <= byte_idx_d;
            gap_q      <= gap_d;
            go_q       <= go_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_letter_ps2_encoder.sv
module tb_letter_ps2_encoder;

    localparam int CD    = 4;
    localparam int GAP   = 8;
    localparam int FRAME = 22 * CD + GAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] in_a, in_b;
    logic       vld_a, vld_b;
    logic [1:0] rdy, pc, pd, bsy, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] frq0[$];
    logic [10:0] frq1[$];
    int          nb[2];
    int          fall_cnt[2];
    int          stab_err[2];
    logic [10:0] shreg[2];
    logic        prev_c[2];
    logic        prev_d[2];

    letter_ps2_encoder #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .SEND_BREAK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .letter_in(in_a), .letter_valid(vld_a),
        .letter_ready(rdy[0]), .ps2_clk_out(pc[0]), .ps2_data_out(pd[0]),
        .busy(bsy[0]), .code_err(err[0])
    );

    letter_ps2_encoder #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .SEND_BREAK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .letter_in(in_b), .letter_valid(vld_b),
        .letter_ready(rdy[1]), .ps2_clk_out(pc[1]), .ps2_data_out(pd[1]),
        .busy(bsy[1]), .code_err(err[1])
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: Set-2 make code per letter, -1 for unmapped
    function automatic int ref_scan(input int l);
        int tab [0:31] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33,
                           'h43, 'h3B, 'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D,
                           'h15, 'h2D, 'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22,
                           'h35, 'h1A, -1, -1, -1, -1, -1, 'h5A};
        return tab[l];
    endfunction

    // Reference frame, bit k = value seen at the k-th falling clock edge
    function automatic int ref_frame(input int b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 1) != 0;
            ones += (b >> i) & 1;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return int'(f);
    endfunction

    function automatic int nframes(input int sel);
        return (sel == 0) ? frq0.size() : frq1.size();
    endfunction

    function automatic int get_frame(input int sel, input int k);
        if (k >= nframes(sel)) return -1;
        return (sel == 0) ? int'(frq0[k]) : int'(frq1[k]);
    endfunction

    task automatic clear_mon(input int sel);
        if (sel == 0) frq0.delete(); else frq1.delete();
        fall_cnt[sel] = 0;
        stab_err[sel] = 0;
    endtask

    task automatic drive(input int sel, input logic v, input logic [4:0] l);
        if (sel == 0) begin vld_a = v; in_a = l; end
        else begin vld_b = v; in_b = l; end
    endtask

    // Frame decoder and low-phase data stability monitor, both instances
    initial begin
        for (int i = 0; i < 2; i++) begin
            nb[i] = 0; prev_c[i] = 1'b1; prev_d[i] = 1'b1; shreg[i] = '0;
            fall_cnt[i] = 0; stab_err[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    nb[i] = 0; prev_c[i] = 1'b1; prev_d[i] = 1'b1;
                end else begin
                    if (prev_c[i] && !pc[i]) begin
                        fall_cnt[i]++;
                        shreg[i][nb[i]] = pd[i];
                        nb[i]++;
                        if (nb[i] == 11) begin
                            if (i == 0) frq0.push_back(shreg[i]);
                            else frq1.push_back(shreg[i]);
                            nb[i] = 0;
                        end
                    end
                    if (!prev_c[i] && !pc[i] && (pd[i] != prev_d[i])) stab_err[i]++;
                    prev_c[i] = pc[i];
                    prev_d[i] = pd[i];
                end
            end
        end
    end

    task automatic wait_ready(input int sel);
        int budget;
        budget = 0;
        while (!rdy[sel] && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("ready_before_send", int'(rdy[sel]), 1);
    endtask

    task automatic send_letter(input int sel, input int ltr, input bit noisy);
        int cyc, t_start, t_ready, busy_n, err_n, nf, sc;
        int exp_b[$];
        logic nv;
        sc = ref_scan(ltr);
        if (sc >= 0) begin
            exp_b.push_back(sc);
            if (sel == 0) begin
                exp_b.push_back('hF0);
                exp_b.push_back(sc);
            end
        end
        nf = exp_b.size();
        wait_ready(sel);
        clear_mon(sel);
        drive(sel, 1'b1, 5'(ltr));
        @(negedge clk);
        cyc = 0; t_start = -1; t_ready = -1; busy_n = 0; err_n = 0;
        forever begin
            if (bsy[sel]) busy_n++;
            if (err[sel]) err_n++;
            if (!pd[sel] && t_start < 0) t_start = cyc;
            if (rdy[sel]) begin
                t_ready = cyc;
                break;
            end
            if (cyc >= 4000) break;
            nv = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(sel, nv, 5'($urandom_range(0, 31)));
            @(negedge clk);
            cyc++;
        end
        drive(sel, 1'b0, 5'd0);
        check_eq($sformatf("ready_returned_l%0d", ltr), int'(t_ready >= 0), 1);
        if (nf == 0) begin
            check_eq("err_pulse_len", err_n, 1);
            check_eq("err_ready_back", t_ready, 1);
            check_eq("err_busy_cycles", busy_n, 0);
            check_eq("err_clk_edges", fall_cnt[sel], 0);
        end else begin
            check_eq("start_latency", t_start, 1);
            check_eq("keystroke_len", t_ready - t_start, nf * FRAME);
            // busy rises on the accept edge, one cycle ahead of the start bit
            check_eq("busy_cycles", busy_n, nf * FRAME + 1);
            check_eq("no_code_err", err_n, 0);
            check_eq("clk_falls", fall_cnt[sel], 11 * nf);
            check_eq("data_stable_low", stab_err[sel], 0);
            check_eq("frame_count", nframes(sel), nf);
            for (int k = 0; k < nf; k++)
                check_eq($sformatf("frame%0d_l%0d", k, ltr), get_frame(sel, k), ref_frame(exp_b[k]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        vld_a = 1'b0; vld_b = 1'b0; in_a = 5'd0; in_b = 5'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_ps2_clk", int'(pc[s]), 1);
            check_eq("rst_ps2_data", int'(pd[s]), 1);
            check_eq("rst_ready", int'(rdy[s]), 1);
            check_eq("rst_busy", int'(bsy[s]), 0);
            check_eq("rst_code_err", int'(err[s]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        send_letter(0, 0, 1'b0);
        check_eq("a_make_bits", get_frame(0, 0), int'(11'b10000111000));
        check_eq("a_break_bits", get_frame(0, 1), int'(11'b11111100000));
        send_letter(0, 31, 1'b0);
        check_eq("entr_bits", get_frame(0, 0), int'(11'b11010110100));
        send_letter(0, 12, 1'b0);
        send_letter(0, 27, 1'b0);
        send_letter(0, 3, 1'b1);
        send_letter(0, 29, 1'b1);
        for (int r = 0; r < 8; r++)
            send_letter(0, int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));

        // Abort in data bit 4 of the F0 frame
        wait_ready(0);
        clear_mon(0);
        drive(0, 1'b1, 5'd0);
        @(negedge clk);
        drive(0, 1'b0, 5'd0);
        budget = 0;
        while (!(frq0.size() == 1 && nb[0] == 5) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("reach_f0_bit4", int'(budget < 2000), 1);
        repeat (5) @(negedge clk);
        check_eq("midframe_busy", int'(bsy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_ps2_clk", int'(pc[0]), 1);
        check_eq("abort_ps2_data", int'(pd[0]), 1);
        check_eq("abort_ready", int'(rdy[0]), 1);
        check_eq("abort_busy", int'(bsy[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_letter(0, 16, 1'b0);

        send_letter(1, 25, 1'b0);
        send_letter(1, 28, 1'b0);
        for (int r = 0; r < 3; r++)
            send_letter(1, int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
